booth_mul_seq: RTL and testbench

BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

---
 rtl/booth_mul_seq.sv | 110 +++++++++++
 tb/tb_booth_mul_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_seq.sv
// ---------------------------------------------------------------------------
// booth_mul_seq
// Sequential 32x32 signed multiplier using radix-2 Booth recoding. One Booth
// iteration is performed per clock. Every operation has the same latency:
// start is accepted at edge N, and done_o is high for one cycle after edge N+33.
//
// Ports
//   clk_i      in   1   clock; all state updates on the rising edge
//   rst_i      in   1   synchronous, active-high reset
//   start_i    in   1   begin a multiply (sampled in IDLE only)
//   a_i        in  32   multiplicand, two's complement
//   b_i        in  32   multiplier, two's complement
//   busy_o     out  1   high in RUN and DONE
//   done_o     out  1   one-cycle pulse, product valid
//   prod_hi_o  out 32   signed product [63:32]
//   prod_lo_o  out 32   signed product [31:0]
// ---------------------------------------------------------------------------
module booth_mul_seq (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] prod_hi_o,
  output logic [31:0] prod_lo_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [5:0] N_ITER  = 6'd32;

  logic [1:0]  r_state;
  logic [32:0] r_a;      // accumulator, one guard bit so M = -2^31 cannot overflow
  logic [31:0] r_q;      // multiplier; product low half shifts in from the top
  logic        r_qm1;    // bit shifted out of Q on the previous iteration
  logic [32:0] r_m;      // sign-extended multiplicand
  logic [5:0]  r_cnt;
  logic [31:0] r_prod_hi;
  logic [31:0] r_prod_lo;

  logic [32:0] w_sum;

  // Booth recoding of {Q[0], q_m1}: 01 adds M, 10 subtracts M, else no change.
  // NOTE: assigning a default before the case keeps every path driven, so no latch.
  always_comb begin
    w_sum = r_a;
    case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_a + r_m;
      2'b10:   w_sum = r_a - r_m;
      default: w_sum = r_a;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_q       <= '0;
      r_qm1     <= 1'b0;
      r_m       <= '0;
      r_cnt     <= '0;
      r_prod_hi <= '0;
      r_prod_lo <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state <= ST_RUN;
            r_a     <= '0;
            r_q     <= b_i;
            r_qm1   <= 1'b0;
            r_m     <= {a_i[31], a_i};
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          if (r_cnt == N_ITER) begin
            // All iterations done; capture the product as DONE is entered.
            r_state   <= ST_DONE;
            r_prod_hi <= r_a[31:0];
            r_prod_lo <= r_q;
          end else begin
            // Arithmetic right shift of {sum, Q, q_m1} by one.
            r_a   <= {w_sum[32], w_sum[32:1]};
            r_q   <= {w_sum[0], r_q[31:1]};
            r_qm1 <= r_q[0];
            r_cnt <= r_cnt + 6'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o    = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign done_o    = (r_state == ST_DONE);
  assign prod_hi_o = r_prod_hi;
  assign prod_lo_o = r_prod_lo;

endmodule

// File: tb/tb_booth_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_booth_mul_seq
// Directed and random checks of booth_mul_seq: reset values, fixed latency,
// corner-case products, ignored starts, mid-operation reset, back-to-back
// operation, and random signed pairs against a 64-bit reference multiply.
// ---------------------------------------------------------------------------
module tb_booth_mul_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] prod_hi_o;
  logic [31:0] prod_lo_o;

  int total = 0;
  int bad   = 0;

  booth_mul_seq dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .prod_hi_o (prod_hi_o),
    .prod_lo_o (prod_lo_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    return ea * eb;
  endfunction

  // Runs one multiply. Start is asserted at the negedge after 'gap' idle
  // negedges. intr_cyc: cycle at which a stray start with new operands is
  // pulsed. rst_cyc: cycle after which reset is asserted (task returns then).
  // poke_done: drive start during the DONE cycle. Latency is counted in edges
  // after the accepting edge; -1 means done never came.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int gap,
                        input int intr_cyc, input int rst_cyc, input bit poke_done,
                        output logic [63:0] prod, output int lat,
                        output bit busy_ok, output bit tail_ok);
    prod    = '0;
    lat     = -1;
    busy_ok = 1'b1;
    tail_ok = 1'b1;
    repeat (gap) @(negedge clk_i);
    @(negedge clk_i);
    start_i = 1'b1;
    a_i     = a;
    b_i     = b;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    a_i     = $urandom;
    b_i     = $urandom;
    if (!busy_o) busy_ok = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk_i);
      #1;
      if (!busy_o) busy_ok = 1'b0;
      if (done_o) begin
        lat  = cyc;
        prod = {prod_hi_o, prod_lo_o};
        break;
      end
      if (cyc == rst_cyc) begin
        rst_i = 1'b1;
        return;
      end
      if (cyc == intr_cyc) begin
        start_i = 1'b1;
        a_i     = 32'd7;
        b_i     = 32'd7;
      end else begin
        start_i = 1'b0;
      end
    end
    if (lat < 0) return;
    if (poke_done) start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    if (done_o || busy_o) tail_ok = 1'b0;
  endtask

  logic [63:0] prod;
  int          lat;
  bit          busy_ok;
  bit          tail_ok;
  logic [31:0] ra;
  logic [31:0] rb;
  int          rnd_lat_bad;
  int          extra_done;

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_busy", {63'd0, busy_o}, 64'd0);
    check("reset_done", {63'd0, done_o}, 64'd0);
    check("reset_prod", {prod_hi_o, prod_lo_o}, 64'd0);
    rst_i = 1'b0;

    // 2 * -2, with start asserted right after reset release.
    run_op(32'd2, 32'hFFFF_FFFE, 0, -1, -1, 1'b0, prod, lat, busy_ok, tail_ok);
    check("lat_2xm2", 64'(lat), 64'd33);
    check("prod_2xm2", prod, 64'hFFFF_FFFF_FFFF_FFFC);
    check("busy_2xm2", {63'd0, busy_ok}, 64'd1);
    check("tail_2xm2", {63'd0, tail_ok}, 64'd1);

    // Product must hold while idle.
    repeat (4) @(posedge clk_i);
    #1;
    check("hold_prod", {prod_hi_o, prod_lo_o}, 64'hFFFF_FFFF_FFFF_FFFC);

    run_op(32'h8000_0000, 32'h8000_0000, 0, -1, -1, 1'b0, prod, lat, busy_ok, tail_ok);
    check("prod_min_min", prod, 64'h4000_0000_0000_0000);

    run_op(32'h7FFF_FFFF, 32'h8000_0000, 0, -1, -1, 1'b0, prod, lat, busy_ok, tail_ok);
    check("prod_max_min", prod, 64'hC000_0000_8000_0000);
    run_op(32'h0, 32'h1234_5678, 0, -1, -1, 1'b0, prod, lat, busy_ok, tail_ok);
    check("prod_zero_b2b", prod, 64'd0);
    check("lat_zero_b2b", 64'(lat), 64'd33);

    // Stray start at cycle 10 must not restart or recapture.
    run_op(32'd3, 32'd5, 0, 10, -1, 1'b0, prod, lat, busy_ok, tail_ok);
    check("prod_ignore_start", prod, 64'd15);
    check("busy_ignore_start", {63'd0, busy_ok}, 64'd1);
    check("lat_ignore_start", 64'(lat), 64'd33);
    extra_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i);
      #1;
      if (done_o || busy_o) extra_done++;
    end
    check("no_second_done", 64'(extra_done), 64'd0);

    // Start during DONE must be ignored.
    run_op(32'd6, 32'd7, 0, -1, -1, 1'b1, prod, lat, busy_ok, tail_ok);
    check("prod_6x7", prod, 64'd42);
    check("start_in_done_ignored", {63'd0, tail_ok}, 64'd1);

    // Reset at iteration 16 abandons the operation.
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, 16, 1'b0, prod, lat, busy_ok, tail_ok);
    check("rst_mid_no_done", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
    extra_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i);
      #1;
      if (done_o || busy_o) extra_done++;
    end
    check("rst_mid_quiet", 64'(extra_done), 64'd0);
    check("rst_mid_prod", {prod_hi_o, prod_lo_o}, 64'd0);
    // Release reset and start on the same negedge: first edge must accept.
    @(negedge clk_i);
    rst_i   = 1'b0;
    start_i = 1'b1;
    a_i     = 32'hFFFF_FFFF;
    b_i     = 32'hFFFF_FFFF;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    check("rst_release_accept", {63'd0, busy_o}, 64'd1);
    lat = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk_i);
      #1;
      if (done_o) begin
        lat = cyc;
        break;
      end
    end
    check("lat_after_rst", 64'(lat), 64'd33);
    check("prod_m1xm1", {prod_hi_o, prod_lo_o}, 64'd1);
    @(posedge clk_i);
    #1;

    // Random signed pairs, random idle gaps.
    rnd_lat_bad = 0;
    for (int n = 0; n < 1500; n++) begin
      case (n)
        0:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        1:       begin ra = 32'hFFFF_FFFF; rb = 32'h8000_0000; end
        2:       begin ra = 32'h7FFF_FFFF; rb = 32'h7FFF_FFFF; end
        default: begin ra = $urandom;      rb = $urandom;      end
      endcase
      run_op(ra, rb, $urandom_range(0, 5), -1, -1, 1'b0, prod, lat, busy_ok, tail_ok);
      check($sformatf("rnd%0d_%08h_x_%08h", n, ra, rb), prod, ref_mul(ra, rb));
      if (lat != 33 || !busy_ok || !tail_ok) rnd_lat_bad++;
    end
    check("rnd_timing", 64'(rnd_lat_bad), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
